seq_pack_writer: RTL and testbench
==================================

SEQ_PACK_WRITER -- requirements
Module: seq_pack_writer

Interface
REQ-001 SHALL have parameter ram_width, default 8, bits per RAM word.
REQ-002 SHALL have parameter addr_size, default 5, RAM address width; depth is 2**addr_size words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bit_in  input  1  serial data bit.
REQ-006 SHALL have port bit_valid  input  1  bit_in is offered this cycle.
REQ-007 SHALL have port bit_ready  output  1  block accepts a bit this cycle.
REQ-008 SHALL have port flush  input  1  single-cycle request to write any partial word.
REQ-009 SHALL have port wr_en  output  1  RAM write strobe, connects to RAM en_write.
REQ-010 SHALL have port wr_addr  output  addr_size  RAM write address.
REQ-011 SHALL have port wr_data  output  ram_width  RAM write data, connects to RAM data_in.
REQ-012 SHALL have port full  output  1  every RAM word written.
REQ-013 SHALL have port word_count  output  addr_size+1  number of words written since reset.

Function
REQ-014 SHALL accept a bit on any rising edge where bit_valid and bit_ready are both 1; no other bit is consumed.
REQ-015 SHALL pack bits MSB first: first accepted bit of a word lands in wr_data[ram_width-1], last in wr_data[0].
REQ-016 SHALL keep a bit counter 0..ram_width-1; the ram_width-th accepted bit completes a word.
REQ-017 SHALL assert wr_en for exactly one cycle, the cycle after the completing bit is accepted, with wr_data = packed word and wr_addr = current write address.
REQ-018 SHALL increment wr_addr and word_count by 1 on the edge ending each wr_en cycle.
REQ-019 SHALL hold wr_data and wr_addr stable while wr_en is 0; wr_en, wr_addr, wr_data are registered outputs.
REQ-020 SHALL, on flush with bit counter > 0, write the partial word with unfilled LSBs zero, via one wr_en cycle the next cycle, then clear the bit counter.
REQ-021 SHALL ignore flush when bit counter = 0 (no write).
REQ-022 SHALL, when bit_valid accept and flush coincide, include that bit first, then flush; if that bit completes a word, exactly one write occurs.
REQ-023 SHALL keep bit_ready = !full; accepting a bit during a wr_en cycle is allowed (back-to-back words with no bubble).
REQ-024 SHALL compute full = (word_count == 2**addr_size).

Reset
REQ-025 SHALL, while rst = 1, force wr_en=0, wr_addr=0, wr_data=0, word_count=0, full=0, bit counter=0, shift register=0, bit_ready=1.
REQ-026 SHALL discard any partial word when rst asserts mid-word; no write is issued for it.
REQ-027 SHALL abort a pending write (wr_en scheduled next cycle) when rst asserts; wr_en stays 0.

Configuration
REQ-028 SHALL provide macro SEQ_PACK_ADDR_WRAP_EN.
REQ-029 SHALL, without SEQ_PACK_ADDR_WRAP_EN, stop at full: full stays 1, bit_ready stays 0, flush ignored, wr_addr stays at 2**addr_size-1, until rst.
REQ-030 SHALL, with SEQ_PACK_ADDR_WRAP_EN, wrap wr_addr from 2**addr_size-1 to 0, word_count saturates at 2**addr_size, full stays 0, bit_ready stays 1, writes continue overwriting oldest words.

Verification
REQ-031 SHALL cover: bits 0,0,1,0,0,1,0,1 with bit_valid=1 after reset -> one cycle later wr_en=1, wr_addr=0, wr_data=8'h25; then wr_addr=1, word_count=1.
REQ-032 SHALL cover: 3 bits 1,1,0 then flush -> next cycle wr_en=1, wr_data=8'hC0, wr_addr=0; second flush produces no write.
REQ-033 SHALL cover: 16 contiguous bits (8'hFF then 8'h00) -> two single-cycle wr_en pulses, addresses 0 and 1, no stall.
REQ-034 SHALL cover: 32 full words without macro -> full=1, bit_ready=0, 33rd word bits ignored, no further wr_en.
REQ-035 SHALL cover: same with SEQ_PACK_ADDR_WRAP_EN -> 33rd word written at wr_addr=0, full=0.
REQ-036 SHALL cover: rst pulse after 5 bits -> no write; next 8 bits 8'h01 written at wr_addr=0 with wr_data=8'h01.

Source files
------------

// File: rtl/seq_pack_writer.sv
// Serial-to-parallel packer: gathers bits MSB first into ram_width-bit words and emits one RAM write per word.
// Optional macro SEQ_PACK_ADDR_WRAP_EN: wrap the write address and keep writing instead of stopping at full.
module seq_pack_writer #(
    parameter int ram_width = 8,
    parameter int addr_size = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    input  logic                 flush,
    output logic                 wr_en,
    output logic [addr_size-1:0] wr_addr,
    output logic [ram_width-1:0] wr_data,
    output logic                 full,
    output logic [addr_size:0]   word_count
);

    localparam int CW = $clog2(ram_width + 1);
    localparam logic [CW-1:0] WORD_BITS = CW'(ram_width);
    localparam logic [addr_size:0] DEPTH = {1'b1, {addr_size{1'b0}}};
`ifndef SEQ_PACK_ADDR_WRAP_EN
    localparam logic [addr_size:0] LAST_SLOT = {1'b0, {addr_size{1'b1}}};
`endif

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ram_width-1:0] acc_q, acc_d;
    logic                 wr_en_q, wr_en_d;
    logic [addr_size-1:0] wr_addr_q, wr_addr_d;
    logic [ram_width-1:0] wr_data_q, wr_data_d;
    logic [addr_size:0]   word_count_q, word_count_d;

    logic                 accept;
    logic                 write_ok;
    logic                 write_now;
    logic [CW-1:0]        filled;
    logic [ram_width-1:0] acc_next;

`ifdef SEQ_PACK_ADDR_WRAP_EN
    assign full     = 1'b0;
    assign write_ok = 1'b1;
`else
    // Once the final slot is being committed, nothing more may be scheduled.
    assign full     = (word_count_q == DEPTH);
    assign write_ok = !full && !(wr_en_q && (word_count_q == LAST_SLOT));
`endif

    assign bit_ready  = !full;
    assign accept     = bit_valid && bit_ready;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;

    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < ram_width; i++) begin
            if (accept && (int'(cnt_q) == ram_width - 1 - i)) begin
                acc_next[i] = bit_in;
            end
        end
        filled    = accept ? (cnt_q + CW'(1)) : cnt_q;
        // A coincident bit is folded in before the flush, so a completing bit plus flush is one write.
        write_now = write_ok && ((filled == WORD_BITS) || (flush && (filled != '0)));

        cnt_d        = filled;
        acc_d        = acc_next;
        wr_en_d      = write_now;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;

        if (write_now) begin
            wr_data_d = acc_next;
            acc_d     = '0;
            cnt_d     = '0;
        end

        if (wr_en_q) begin
            word_count_d = (word_count_q == DEPTH) ? DEPTH : (word_count_q + 1'b1);
`ifdef SEQ_PACK_ADDR_WRAP_EN
            wr_addr_d = wr_addr_q + 1'b1;
`else
            if (word_count_q != LAST_SLOT) begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_seq_pack_writer.sv
// Directed self-checking bench for seq_pack_writer (8-bit words, 32-word RAM).
module tb_seq_pack_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       flush = 1'b0;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       full;
    logic [5:0] word_count;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    seq_pack_writer #(.ram_width(8), .addr_size(5)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .full(full), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) pulses++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bit_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    // Offers one bit (optionally with flush) for one clock; returns #1 after the edge.
    task automatic send_bit(input logic b, input logic f);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in = b;
        flush = f;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_wr_data got=%h exp=00", wr_data); end
        total++; if (word_count !== 6'd0) begin bad++; $display("[TB] FAIL reset_word_count got=%0d exp=0", word_count); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        total++; if (bit_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_bit_ready got=%b exp=1", bit_ready); end
        rst = 1'b0;
        pulses = 0;
    endtask

    task automatic test_basic_word();
        logic [7:0] pat;
        do_reset();
        pat = 8'b0010_0101;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i], 1'b0);
            if (i != 0) begin
                total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_wr_en bit=%0d got=%b exp=0", 7 - i, wr_en); end
            end
        end
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL basic_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'h25) begin bad++; $display("[TB] FAIL basic_wr_data got=%h exp=25", wr_data); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL basic_wr_addr got=%0d exp=0", wr_addr); end
        step();
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL basic_wr_en_drop got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 5'd1) begin bad++; $display("[TB] FAIL basic_addr_inc got=%0d exp=1", wr_addr); end
        total++; if (word_count !== 6'd1) begin bad++; $display("[TB] FAIL basic_word_count got=%0d exp=1", word_count); end
        total++; if (wr_data !== 8'h25) begin bad++; $display("[TB] FAIL basic_data_hold got=%h exp=25", wr_data); end
    endtask

    task automatic test_flush();
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL flush_pre_wr_en got=%b exp=0", wr_en); end
        pulse_flush();
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL flush_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'hC0) begin bad++; $display("[TB] FAIL flush_wr_data got=%h exp=c0", wr_data); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL flush_wr_addr got=%0d exp=0", wr_addr); end
        step();
        pulse_flush();
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty_wr_en got=%b exp=0", wr_en); end
        step();
        total++; if (word_count !== 6'd1) begin bad++; $display("[TB] FAIL flush_word_count got=%0d exp=1", word_count); end
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL flush_pulses got=%0d exp=1", pulses); end
        // A bit with flush that does not complete a word is included before the partial write.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL flush_coincide_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'hA0) begin bad++; $display("[TB] FAIL flush_coincide_data got=%h exp=a0", wr_data); end
        total++; if (wr_addr !== 5'd1) begin bad++; $display("[TB] FAIL flush_coincide_addr got=%0d exp=1", wr_addr); end
    endtask

    task automatic test_flush_on_complete();
        logic [7:0] pat;
        do_reset();
        pat = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(pat[i], 1'b0);
        send_bit(pat[0], 1'b1);
        total++; if (wr_data !== 8'h5A) begin bad++; $display("[TB] FAIL complete_flush_data got=%h exp=5a", wr_data); end
        step();
        step();
        total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL complete_flush_pulses got=%0d exp=1", pulses); end
        total++; if (word_count !== 6'd1) begin bad++; $display("[TB] FAIL complete_flush_count got=%0d exp=1", word_count); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        do_reset();
        pat = 16'hFF00;
        for (int i = 15; i >= 0; i--) begin
            total++; if (bit_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready idx=%0d got=%b exp=1", 15 - i, bit_ready); end
            send_bit(pat[i], 1'b0);
            if (i == 8) begin
                total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_wr_en got=%b exp=1", wr_en); end
                total++; if (wr_data !== 8'hFF) begin bad++; $display("[TB] FAIL b2b_first_data got=%h exp=ff", wr_data); end
                total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL b2b_first_addr got=%0d exp=0", wr_addr); end
            end
            if (i == 7) begin
                total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL b2b_gap_wr_en got=%b exp=0", wr_en); end
                total++; if (wr_addr !== 5'd1) begin bad++; $display("[TB] FAIL b2b_gap_addr got=%0d exp=1", wr_addr); end
            end
        end
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("[TB] FAIL b2b_second_data got=%h exp=00", wr_data); end
        total++; if (wr_addr !== 5'd1) begin bad++; $display("[TB] FAIL b2b_second_addr got=%0d exp=1", wr_addr); end
        step();
        total++; if (word_count !== 6'd2) begin bad++; $display("[TB] FAIL b2b_word_count got=%0d exp=2", word_count); end
        total++; if (pulses !== 2) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d exp=2", pulses); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 32; k++) send_word(8'(k));
        total++; if (wr_data !== 8'h1F) begin bad++; $display("[TB] FAIL fill_last_data got=%h exp=1f", wr_data); end
        total++; if (wr_addr !== 5'd31) begin bad++; $display("[TB] FAIL fill_last_addr got=%0d exp=31", wr_addr); end
        step();
        total++; if (word_count !== 6'd32) begin bad++; $display("[TB] FAIL fill_word_count got=%0d exp=32", word_count); end
        total++; if (pulses !== 32) begin bad++; $display("[TB] FAIL fill_pulses got=%0d exp=32", pulses); end
`ifdef SEQ_PACK_ADDR_WRAP_EN
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL wrap_full got=%b exp=0", full); end
        total++; if (bit_ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ready got=%b exp=1", bit_ready); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL wrap_addr got=%0d exp=0", wr_addr); end
        send_word(8'hA5);
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL wrap_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'hA5) begin bad++; $display("[TB] FAIL wrap_data got=%h exp=a5", wr_data); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL wrap_33_addr got=%0d exp=0", wr_addr); end
        step();
        total++; if (word_count !== 6'd32) begin bad++; $display("[TB] FAIL wrap_count_sat got=%0d exp=32", word_count); end
        total++; if (wr_addr !== 5'd1) begin bad++; $display("[TB] FAIL wrap_addr_next got=%0d exp=1", wr_addr); end
        total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL wrap_full_after got=%b exp=0", full); end
`else
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL stop_full got=%b exp=1", full); end
        total++; if (bit_ready !== 1'b0) begin bad++; $display("[TB] FAIL stop_ready got=%b exp=0", bit_ready); end
        total++; if (wr_addr !== 5'd31) begin bad++; $display("[TB] FAIL stop_addr got=%0d exp=31", wr_addr); end
        send_word(8'hA5);
        pulse_flush();
        step();
        step();
        total++; if (pulses !== 32) begin bad++; $display("[TB] FAIL stop_pulses got=%0d exp=32", pulses); end
        total++; if (word_count !== 6'd32) begin bad++; $display("[TB] FAIL stop_count got=%0d exp=32", word_count); end
        total++; if (wr_addr !== 5'd31) begin bad++; $display("[TB] FAIL stop_addr_hold got=%0d exp=31", wr_addr); end
        total++; if (wr_data !== 8'h1F) begin bad++; $display("[TB] FAIL stop_data_hold got=%h exp=1f", wr_data); end
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL stop_full_hold got=%b exp=1", full); end
`endif
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        do_reset();
        step();
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL midrst_pulses got=%0d exp=0", pulses); end
        send_word(8'h01);
        total++; if (wr_en !== 1'b1) begin bad++; $display("[TB] FAIL midrst_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_data !== 8'h01) begin bad++; $display("[TB] FAIL midrst_data got=%h exp=01", wr_data); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("[TB] FAIL midrst_addr got=%0d exp=0", wr_addr); end
        // Reset raised while the completing bit is offered must cancel the write.
        step();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in = 1'b1;
        rst = 1'b1;
        pulses = 0;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        total++; if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL abort_wr_en got=%b exp=0", wr_en); end
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL abort_pulses got=%0d exp=0", pulses); end
        total++; if (word_count !== 6'd0) begin bad++; $display("[TB] FAIL abort_count got=%0d exp=0", word_count); end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_flush();
        test_flush_on_complete();
        test_back_to_back();
        test_fill();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
